// File: rtl/sat_pkg.sv
// Shared types and sizing for the DPLL solver blocks.
package sat_pkg;
  localparam int NUM_VARS = 64;
  localparam int VAR_W    = $clog2(NUM_VARS);
  localparam int LVL_W    = $clog2(NUM_VARS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    POP  = 1'b1
  } bt_state_e;

  typedef struct packed {
    logic [VAR_W-1:0] vid;
    logic             val;
    logic             is_dec;
  } trail_entry_t;
endpackage

// File: rtl/trail_ram.sv
// Trail storage: synchronous write, asynchronous read.
module trail_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/trail_stack.sv
// Assignment trail: ordered push of decisions/implications, one-pop-per-cycle
// backtrack to the most recent decision with its value flipped.
module trail_stack #(
  parameter int NUM_VARS = 64,
  parameter int VAR_W    = $clog2(NUM_VARS),
  parameter int LVL_W    = $clog2(NUM_VARS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [VAR_W-1:0] push_var,
  input  logic             push_val,
  input  logic             push_is_dec,
  output logic             push_ready,
  input  logic             bt_start,
  output logic             unassign_valid,
  output logic [VAR_W-1:0] unassign_var,
  output logic             bt_done,
  output logic [VAR_W-1:0] bt_var,
  output logic             bt_val,
  output logic             bt_empty,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] count,
  output logic             full
);
  import sat_pkg::*;

  typedef struct packed {
    logic [VAR_W-1:0] vid;
    logic             val;
    logic             is_dec;
  } entry_t;

  bt_state_e        state, state_nx;
  logic [LVL_W-1:0] sp, lvl;
  entry_t           top_e, wr_e;
  logic             push_fire, pop_fire, sp_zero;

  assign sp_zero   = (sp == '0);
  assign full      = (sp == LVL_W'(NUM_VARS));
  assign count     = sp;
  assign level     = lvl;
  assign wr_e      = '{vid: push_var, val: push_val, is_dec: push_is_dec};
  assign push_fire = push_valid && push_ready;

  // Read port always points at the top entry (sp-1); only used when sp>0.
  trail_ram #(.DEPTH(NUM_VARS), .AW(VAR_W), .W(VAR_W + 2)) u_ram (
    .clk   (clk),
    .we    (push_fire),
    .waddr (VAR_W'(sp)),
    .wdata (wr_e),
    .raddr (VAR_W'(sp - LVL_W'(1))),
    .rdata (top_e)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bt_start) state_nx = POP;
      POP:     if (sp_zero || top_e.is_dec) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    push_ready = 1'b0;
    pop_fire   = 1'b0;
    case (state)
      IDLE:    push_ready = !full && !bt_start;
      POP:     pop_fire   = !sp_zero;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp             <= '0;
      lvl            <= '0;
      unassign_valid <= 1'b0;
      unassign_var   <= '0;
      bt_done        <= 1'b0;
      bt_var         <= '0;
      bt_val         <= 1'b0;
      bt_empty       <= 1'b0;
    end else begin
      unassign_valid <= 1'b0;
      bt_done        <= 1'b0;
      if (push_fire) begin
        sp <= sp + LVL_W'(1);
        if (push_is_dec) lvl <= lvl + LVL_W'(1);
      end
      if (pop_fire) begin
        sp             <= sp - LVL_W'(1);
        unassign_valid <= 1'b1;
        unassign_var   <= top_e.vid;
        if (top_e.is_dec) begin
          lvl      <= lvl - LVL_W'(1);
          bt_done  <= 1'b1;
          bt_var   <= top_e.vid;
          bt_val   <= ~top_e.val;
          bt_empty <= 1'b0;
        end
      end else if (state == POP) begin
        // Trail drained without meeting a decision: search space exhausted.
        bt_done  <= 1'b1;
        bt_empty <= 1'b1;
      end
    end
  end
endmodule
